uart_tx_serializer: RTL

- Transmit stage of the UART core. Sits directly downstream of the 256x8 transmit FIFO.
- Pops one byte at a time through the FIFO's active-low read strobe and serialises it onto the TX line.
- Frame format: start bit, 7 or 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing is taken from a 16x-oversampled baud enable pulse generated by the core's baud generator.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default oversampling ratio
// and the parity helper also used by the receiver's checker.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;

    // With 7-bit frames bit 7 is excluded; odd parity inverts the XOR.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       bit8,
                                         input logic       odd);
        logic [7:0] used;
        used = bit8 ? data : {1'b0, data[6:0]};
        return (^used) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: pops bytes from the TX FIFO and serialises them as
// start / 7-8 data bits LSB first / optional parity / 1-2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_en,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rdb,
    output logic       tx,
    output logic       tx_busy
);

    state_t     state_q, state_d;
    logic [1:0] wait_cnt;
    logic [3:0] tick_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic       cfg_bit8, cfg_par_en, par_bit;
    logic       tx_q, tx_d, rdb_q, busy_q;
    logic       active, bit_end, wait_done, last_data;
    logic       load, shift_en, bit_clr, bit_inc;

    assign active    = state_q inside {START, DATA, PARITY, STOP};
    assign bit_end   = active && baud_en && (tick_cnt == 4'(OVERSAMPLE - 1));
    assign wait_done = (wait_cnt == 2'(RD_LATENCY - 1));
    assign last_data = (bit_cnt == (cfg_bit8 ? 4'd7 : 4'd6));

    // tx_d is the line value for the next cycle, so TX itself is a flop.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        load     = 1'b0;
        shift_en = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                if (wait_done) begin
                    load    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d     = shift_q[0];
                    shift_en = 1'b1;
                    bit_clr  = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        bit_clr = 1'b1;
                        if (cfg_par_en) begin
                            tx_d    = par_bit;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d     = shift_q[0];
                        shift_en = 1'b1;
                        bit_inc  = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    bit_clr = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        bit_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            rdb_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rdb_q   <= (state_d != FETCH);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Frame format is frozen at load so config changes only hit the next byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            cfg_bit8   <= 1'b0;
            cfg_par_en <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            wait_cnt <= (state_q == WAIT) ? wait_cnt + 2'd1 : 2'd0;

            if (load)
                tick_cnt <= '0;
            else if (active && baud_en)
                tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;

            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_inc)
                bit_cnt <= bit_cnt + 4'd1;

            if (load) begin
                shift_q    <= fifo_data;
                cfg_bit8   <= bit8;
                cfg_par_en <= parity_en;
                par_bit    <= calc_parity(fifo_data, bit8, odd_n_even);
            end else if (shift_en) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

    assign tx       = tx_q;
    assign fifo_rdb = rdb_q;
    assign tx_busy  = busy_q;

endmodule
